// File: rtl/reg_map_pkg.sv
// Register-map constants, command-byte layout and decoder state encoding
// shared by the host command decoder and the register blocks it drives.
package reg_map_pkg;

  // Address space: 4-bit address field, 16 slots.
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned DATA_W   = 16;

  // Implemented register addresses.
  localparam logic [ADDR_W-1:0] ADDR_VERSN = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_HWRID = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_CTRL  = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_IRQEN = 4'h3;
  localparam logic [ADDR_W-1:0] ADDR_IRQST = 4'h4;
  localparam logic [ADDR_W-1:0] ADDR_SRCLO = 4'h5;
  localparam logic [ADDR_W-1:0] ADDR_SRCHI = 4'h6;
  localparam logic [ADDR_W-1:0] ADDR_DSTLO = 4'h7;
  localparam logic [ADDR_W-1:0] ADDR_LEN   = 4'h8;
  localparam logic [ADDR_W-1:0] ADDR_STATS = 4'h9;

  // Bit n set: address n exists / address n is read-only.
  localparam logic [NUM_REGS-1:0] IMPL_MASK_DEFAULT = 16'h03FF;
  localparam logic [NUM_REGS-1:0] RO_MASK_DEFAULT   = 16'h0003;

  // Command byte: bit7 selects write, bits 6:4 ignored, bits 3:0 address.
  localparam int unsigned CMD_WRITE_BIT = 7;
  localparam int unsigned CMD_ADDR_MSB  = 3;
  localparam int unsigned CMD_ADDR_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_HI,
    ST_WR_LO,
    ST_WR_COMMIT,
    ST_RD_CAPTURE,
    ST_RD_HI,
    ST_RD_LO
  } state_e;

endpackage

// File: rtl/reg_cmd_decoder.sv
// Purpose: decode host byte-stream read/write frames into register strobes and 2-byte read responses.
// Latency: write strobe 1 cycle after low byte accepted; first response byte valid 2 cycles after read cmd accepted.
// Backpressure: rx_ready_o low during commit/capture/response; tx holds data until tx_ready_i, with no response timeout.
module reg_cmd_decoder
  import reg_map_pkg::*;
#(
  parameter int unsigned          NumRegs       = NUM_REGS,
  parameter logic [NumRegs-1:0]   ImplMask      = NumRegs'(IMPL_MASK_DEFAULT),
  parameter logic [NumRegs-1:0]   RoMask        = NumRegs'(RO_MASK_DEFAULT),
  parameter int unsigned          TimeoutCycles = 1024,
  parameter logic [DATA_W-1:0]    ErrReadValue  = 16'hDEAD
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [7:0]                  rx_data_i,
  input  logic                        rx_valid_i,
  output logic                        rx_ready_o,
  output logic [7:0]                  tx_data_o,
  output logic                        tx_valid_o,
  input  logic                        tx_ready_i,
  output logic [DATA_W-1:0]           reg_wdata_o,
  output logic [NumRegs-1:0]          reg_we_o,
  input  logic [DATA_W*NumRegs-1:0]   reg_rdata_i,
  output logic [NumRegs-1:0]          reg_rd_o,
  output logic                        err_o,
  output logic                        busy_o
);

  localparam int unsigned TW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TimeoutCycles - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          data_hi_q;
  logic [DATA_W-1:0]   shadow_q;
  logic [TW-1:0]       tmo_q;

  logic                rx_fire;
  logic                tx_fire;
  logic [ADDR_W-1:0]   cmd_addr;
  logic                cmd_impl;
  logic                addr_impl;
  logic                addr_writable;
  logic [NumRegs-1:0]  cmd_onehot;
  logic [NumRegs-1:0]  addr_onehot;
  logic [DATA_W-1:0]   rd_val;

  // Handshakes, address decode and the read-back mux for the latched address.
  always_comb begin
    rx_fire       = rx_valid_i && rx_ready_o;
    tx_fire       = tx_valid_o && tx_ready_i;
    cmd_addr      = rx_data_i[CMD_ADDR_MSB:CMD_ADDR_LSB];
    cmd_impl      = ImplMask[cmd_addr];
    addr_impl     = ImplMask[addr_q];
    addr_writable = ImplMask[addr_q] && !RoMask[addr_q];
    cmd_onehot    = NumRegs'(1) << cmd_addr;
    addr_onehot   = NumRegs'(1) << addr_q;
    rd_val        = ErrReadValue;
    if (addr_impl) begin
      rd_val = reg_rdata_i[DATA_W*addr_q +: DATA_W];
    end
  end

  // Frame FSM; every output is registered and set on entry to the state it belongs to.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_hi_q   <= '0;
      shadow_q    <= '0;
      tmo_q       <= '0;
      rx_ready_o  <= 1'b1;
      tx_valid_o  <= 1'b0;
      tx_data_o   <= '0;
      reg_wdata_o <= '0;
      reg_we_o    <= '0;
      reg_rd_o    <= '0;
      err_o       <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      // Strobes and error are single-cycle pulses unless re-asserted below.
      reg_we_o <= '0;
      reg_rd_o <= '0;
      err_o    <= 1'b0;
      if (rx_fire) begin
        tmo_q <= '0;
      end
      case (state_q)
        ST_IDLE: begin
          if (rx_fire) begin
            addr_q <= cmd_addr;
            busy_o <= 1'b1;
            if (rx_data_i[CMD_WRITE_BIT]) begin
              state_q <= ST_WR_HI;
            end else begin
              // Read strobe lands in the capture cycle, same cycle the shadow samples.
              state_q    <= ST_RD_CAPTURE;
              rx_ready_o <= 1'b0;
              reg_rd_o   <= cmd_impl ? cmd_onehot : '0;
              err_o      <= !cmd_impl;
            end
          end
        end
        ST_WR_HI, ST_WR_LO: begin
          if (rx_fire) begin
            if (state_q == ST_WR_HI) begin
              data_hi_q <= rx_data_i;
              state_q   <= ST_WR_LO;
            end else begin
              state_q    <= ST_WR_COMMIT;
              rx_ready_o <= 1'b0;
              if (addr_writable) begin
                reg_wdata_o <= {data_hi_q, rx_data_i};
                reg_we_o    <= addr_onehot;
              end else begin
                err_o <= 1'b1;
              end
            end
          end else if (tmo_q == TMO_LAST) begin
            // Host went quiet mid-frame: drop it without writing.
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_WR_COMMIT: begin
          state_q    <= ST_IDLE;
          rx_ready_o <= 1'b1;
          busy_o     <= 1'b0;
        end
        ST_RD_CAPTURE: begin
          // Shadow keeps the pre-clear value of clear-on-read registers.
          shadow_q   <= rd_val;
          tx_data_o  <= rd_val[15:8];
          tx_valid_o <= 1'b1;
          state_q    <= ST_RD_HI;
        end
        ST_RD_HI: begin
          if (tx_fire) begin
            tx_data_o <= shadow_q[7:0];
            state_q   <= ST_RD_LO;
          end
        end
        ST_RD_LO: begin
          if (tx_fire) begin
            tx_valid_o <= 1'b0;
            rx_ready_o <= 1'b1;
            busy_o     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          rx_ready_o <= 1'b1;
          tx_valid_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_decoder.sv
// Directed bench for reg_cmd_decoder with a small register-file model
// (writes land on strobe, STATS clears on its read strobe).
module tb_reg_cmd_decoder;

  localparam int unsigned NR  = 16;
  localparam int unsigned TMO = 1024;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [7:0]        rx_data_i;
  logic              rx_valid_i;
  logic              rx_ready_o;
  logic [7:0]        tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic [15:0]       reg_wdata_o;
  logic [NR-1:0]     reg_we_o;
  logic [16*NR-1:0]  reg_rdata_i;
  logic [NR-1:0]     reg_rd_o;
  logic              err_o;
  logic              busy_o;

  logic [15:0] regs [NR];
  int n_cmp = 0;
  int n_mis = 0;
  int we_pulses = 0;
  int multihot = 0;

  reg_cmd_decoder #(.TimeoutCycles(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .reg_wdata_o(reg_wdata_o), .reg_we_o(reg_we_o), .reg_rdata_i(reg_rdata_i),
    .reg_rd_o(reg_rd_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Register file model driving the flattened read-back bus.
  always_comb begin
    reg_rdata_i = '0;
    for (int i = 0; i < NR; i++) reg_rdata_i[16*i +: 16] = regs[i];
  end

  always @(posedge clk_i) begin
    for (int i = 0; i < NR; i++) begin
      if (reg_we_o[i]) regs[i] <= reg_wdata_o;
      else if (reg_rd_o[i] && i == 9) regs[i] <= 16'h0000;
    end
  end

  always @(negedge clk_i) begin
    if (reg_we_o != '0) we_pulses++;
    if ($countones(reg_we_o) > 1 || $countones(reg_rd_o) > 1) multihot++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (rx_ready_o) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    rx_valid_i = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    logic ok;
    ok = 1'b0;
    b  = 8'h00;
    tx_ready_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (tx_valid_o) begin
        b = tx_data_o;
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    tx_ready_i = 1'b0;
    if (!ok) chk("recv_timeout", 0, 1);
  endtask

  initial begin
    logic [7:0] b0, b1;
    int cyc;
    int we_before;

    for (int i = 0; i < NR; i++) regs[i] <= 16'h0000;
    regs[0] <= 16'h0102;
    regs[3] <= 16'h5A5A;
    regs[9] <= 16'h0A5F;
    rst_ni = 1'b0; rx_data_i = 8'h00; rx_valid_i = 1'b0; tx_ready_i = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_rx_ready", {31'b0, rx_ready_o}, 1);
    chk("rst_misc", {tx_valid_o, err_o, busy_o, tx_data_o}, 0);
    chk("rst_strobes", {reg_we_o, reg_rd_o}, 0);
    chk("rst_wdata", {16'b0, reg_wdata_o}, 0);
    rst_ni = 1'b1;
    tick();

    // Back-to-back write to address 2
    send_byte(8'h82); send_byte(8'h12); send_byte(8'h34);
    chk("wr2_we", {16'b0, reg_we_o}, 32'h0004);
    chk("wr2_wdata", {16'b0, reg_wdata_o}, 32'h1234);
    chk("wr2_err", {31'b0, err_o}, 0);
    chk("wr2_rx_ready_commit", {31'b0, rx_ready_o}, 0);
    tick();
    chk("wr2_we_one_cycle", {16'b0, reg_we_o}, 0);
    chk("wr2_idle", {rx_ready_o, busy_o}, 2'b10);
    chk("wr2_wdata_hold", {16'b0, reg_wdata_o}, 32'h1234);
    chk("wr2_model", {16'b0, regs[2]}, 32'h1234);

    // Read STATS with a stalled first response byte
    send_byte(8'h09);
    chk("rd9_rd", {16'b0, reg_rd_o}, 32'h0200);
    chk("rd9_cap", {tx_valid_o, err_o, busy_o}, 3'b001);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("rd9_hold_hi", {tx_valid_o, tx_data_o}, 9'h10A);
      chk("rd9_rd_cleared", {16'b0, reg_rd_o}, 0);
      tick();
    end
    recv_byte(b0); recv_byte(b1);
    chk("rd9_resp", {b0, b1}, 16'h0A5F);
    tick();
    chk("rd9_idle", {tx_valid_o, busy_o, rx_ready_o}, 3'b001);
    send_byte(8'h09); recv_byte(b0); recv_byte(b1);
    chk("rd9_after_clear", {b0, b1}, 16'h0000);

    // Write to read-only VERSN
    tick();
    we_before = we_pulses;
    send_byte(8'h80); send_byte(8'hFF); send_byte(8'hFF);
    chk("ro_err", {err_o, busy_o}, 2'b11);
    chk("ro_we", {16'b0, reg_we_o}, 0);
    tick();
    chk("ro_err_pulse", {err_o, busy_o}, 0);
    chk("ro_no_we", we_pulses - we_before, 0);
    chk("ro_model", {16'b0, regs[0]}, 32'h0102);

    // Read unimplemented address 0xC
    send_byte(8'h0C);
    chk("unimpl_rd", {reg_rd_o, err_o}, 17'h00001);
    recv_byte(b0); recv_byte(b1);
    chk("unimpl_resp", {b0, b1}, 16'hDEAD);
    tick();

    // Timeout after partial write frame
    we_before = we_pulses;
    send_byte(8'h83); send_byte(8'h11);
    cyc = 0;
    for (int i = 1; i <= 2000; i++) begin
      tick();
      if (err_o) begin cyc = i; break; end
    end
    chk("tmo_cycles", cyc, TMO);
    chk("tmo_busy", {31'b0, busy_o}, 0);
    chk("tmo_no_we", we_pulses - we_before, 0);
    send_byte(8'h03); recv_byte(b0); recv_byte(b1);
    chk("tmo_old_value", {b0, b1}, 16'h5A5A);
    tick();

    // Reset mid-frame, while the low byte is presented
    we_before = we_pulses;
    send_byte(8'h84); send_byte(8'h22);
    tick();
    rst_ni = 1'b0; rx_data_i = 8'h33; rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
    chk("mrst_outputs", {rx_ready_o, tx_valid_o, err_o, busy_o, tx_data_o}, 12'h800);
    chk("mrst_strobes", {reg_we_o, reg_wdata_o}, 0);
    rst_ni = 1'b1;
    tick();
    chk("mrst_no_we", we_pulses - we_before, 0);
    send_byte(8'h84); send_byte(8'hBE); send_byte(8'hEF);
    chk("mrst_next_we", {reg_we_o, reg_wdata_o}, 32'h0010BEEF);
    tick();
    chk("mrst_model", {16'b0, regs[4]}, 32'hBEEF);

    chk("onehot", multihot, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
